// File: rtl/mem_seq_pkg.sv
// Shared definitions for the memory access sequencer: the sequencer state
// encoding, instruction field positions and the word width.
package mem_seq_pkg;

    localparam int WORD_W     = 32;
    localparam int OPCODE_MSB = 31;
    localparam int OPCODE_LSB = 26;
    localparam int FUNCT_MSB  = 5;
    localparam int FUNCT_LSB  = 0;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        CAPTURE = 2'd2
    } state_t;

    // Larger of two integers, used to size the latency counter.
    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/mem_lat_counter.sv
// Loadable down-counter with a zero flag. Counts the remaining cycles of a
// memory access; it stops at zero rather than wrapping.
module mem_lat_counter #(
    parameter int CNT_W = 2
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic [CNT_W-1:0] count,
    output logic             zero
);

    // Counter register: reset clears, load has priority over decrement.
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/mem_access_seq.sv
// Memory access sequencer: accepts one fetch/load/store per handshake, holds
// the address (and write enable for stores) for the memory's fixed latency,
// captures read data into InstrReg or MDR and pulses Done on completion.
// Optional build macro MEM_ACCESS_ALIGN_CHECK_EN rejects requests whose
// selected address is not word aligned (AlignErr + Done pulse, no access).
module mem_access_seq
    import mem_seq_pkg::*;
#(
    parameter int READ_LATENCY  = 2,
    parameter int WRITE_LATENCY = 1
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              ReqValid,
    output logic              ReqReady,
    input  logic              ReqWrite,
    input  logic              IouD,
    input  logic [WORD_W-1:0] PCAddr,
    input  logic [WORD_W-1:0] ALUOutAddr,
    input  logic [WORD_W-1:0] StoreData,
    output logic [WORD_W-1:0] MemAddr,
    output logic              MemWrite,
    output logic [WORD_W-1:0] MemWData,
    input  logic [WORD_W-1:0] MemRData,
    output logic [WORD_W-1:0] InstrReg,
    output logic [5:0]        OpCode,
    output logic [5:0]        InstrArit,
    output logic [WORD_W-1:0] MDR,
    output logic              Done,
    output logic              AlignErr
);

    localparam int CNT_W = $clog2(max_int(READ_LATENCY, WRITE_LATENCY) + 1);
    localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(READ_LATENCY - 1);
    localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'(WRITE_LATENCY - 1);

    state_t            state, state_nxt;
    logic              wr_lat, iod_lat;
    logic [WORD_W-1:0] sel_addr;
    logic              accept, misaligned, go_access;
    logic              done_nxt, alignerr_nxt, cnt_dec;
    logic [CNT_W-1:0]  cnt;
    logic              cnt_zero;

    assign ReqReady = (state == IDLE);
    assign accept   = ReqValid && ReqReady;
    assign sel_addr = IouD ? ALUOutAddr : PCAddr;

`ifdef MEM_ACCESS_ALIGN_CHECK_EN
    assign misaligned = (sel_addr[1:0] != 2'b00);
`else
    assign misaligned = 1'b0;
`endif

    // A misaligned request is consumed by the handshake but never reaches memory.
    assign go_access = accept && !misaligned;

    mem_lat_counter #(
        .CNT_W(CNT_W)
    ) u_lat_counter (
        .Clock    (Clock),
        .Reset    (Reset),
        .load     (go_access),
        .load_val (ReqWrite ? WR_LOAD : RD_LOAD),
        .dec      (cnt_dec),
        .count    (cnt),
        .zero     (cnt_zero)
    );

    // State register.
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state, write enable, counter decrement and completion decode.
    always_comb begin
        state_nxt    = state;
        done_nxt     = 1'b0;
        alignerr_nxt = 1'b0;
        MemWrite     = 1'b0;
        cnt_dec      = 1'b0;
        case (state)
            IDLE: begin
                if (go_access) begin
                    state_nxt = ACCESS;
                end else if (accept) begin
                    done_nxt     = 1'b1;
                    alignerr_nxt = 1'b1;
                end
            end
            ACCESS: begin
                MemWrite = wr_lat;
                cnt_dec  = 1'b1;
                if (cnt_zero) begin
                    if (wr_lat) begin
                        state_nxt = IDLE;
                        done_nxt  = 1'b1;
                    end else begin
                        state_nxt = CAPTURE;
                    end
                end
            end
            CAPTURE: begin
                state_nxt = IDLE;
                done_nxt  = 1'b1;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Request latch: address, write data and access kind captured on accept.
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            MemAddr  <= '0;
            MemWData <= '0;
            wr_lat   <= 1'b0;
            iod_lat  <= 1'b0;
        end else if (go_access) begin
            MemAddr  <= sel_addr;
            MemWData <= StoreData;
            wr_lat   <= ReqWrite;
            iod_lat  <= IouD;
        end
    end

    // Read data capture: only a read reaches CAPTURE, IouD picks the target.
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            InstrReg <= '0;
            MDR      <= '0;
        end else if (state == CAPTURE) begin
            if (iod_lat) begin
                MDR <= MemRData;
            end else begin
                InstrReg <= MemRData;
            end
        end
    end

    // Registered completion and alignment-error pulses.
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            Done     <= 1'b0;
            AlignErr <= 1'b0;
        end else begin
            Done     <= done_nxt;
            AlignErr <= alignerr_nxt;
        end
    end

    assign OpCode    = InstrReg[OPCODE_MSB:OPCODE_LSB];
    assign InstrArit = InstrReg[FUNCT_MSB:FUNCT_LSB];

endmodule

// File: doc/mem_access_seq.md
# mem_access_seq

Memory access sequencer sitting between the multicycle controller and the instruction/data memory. It accepts one fetch, load or store request per handshake and selects the address from PC or ALUOut. It waits out the memory's fixed read/write latency, then captures read data into the instruction register or the MDR. It signals completion with a one-cycle Done pulse, replacing the controller's hand-counted wait states.

## Interface
Parameters:
- READ_LATENCY, 2, cycles from address presented to MemRData valid; legal range ≥1.
- WRITE_LATENCY, 1, cycles MemWrite must be held for a store; legal range ≥1.

Ports:
- Clock  in  1  system clock, rising edge.
- Reset  in  1  reset Reset, synchronous, active-low; clock Clock.
- ReqValid  in  1  controller requests an access.
- ReqReady  out  1  sequencer can accept; high only in IDLE.
- ReqWrite  in  1  1 = store, 0 = read.
- IouD  in  1  0 = fetch: address PCAddr, destination InstrReg. 1 = data: address ALUOutAddr, destination MDR.
- PCAddr  in  32  program counter.
- ALUOutAddr  in  32  ALUOut register.
- StoreData  in  32  store data (RegB).
- MemAddr  out  32  memory address (latched).
- MemWrite  out  1  memory write enable (CtrMem).
- MemWData  out  32  memory write data (latched).
- MemRData  in  32  memory read data.
- InstrReg  out  32  instruction register.
- OpCode  out  6  InstrReg[31:26].
- InstrArit  out  6  InstrReg[5:0].
- MDR  out  32  memory data register.
- Done  out  1  one-cycle completion pulse.
- AlignErr  out  1  misaligned-request pulse; see Configuration.

## Operation
- Handshake: a request is accepted at a rising edge where ReqValid && ReqReady. No other request is accepted until the sequencer returns to IDLE.
- On accept, latch:
  - address: PCAddr if IouD=0, else ALUOutAddr;
  - ReqWrite and IouD;
  - StoreData into MemWData;
  - load the latency counter with (ReqWrite ? WRITE_LATENCY : READ_LATENCY) − 1.
- States:
  - IDLE: ReqReady=1, MemWrite=0. On accept go to ACCESS.
  - ACCESS: MemAddr holds the latched address. MemWrite equals the latched write flag. The counter decrements each cycle. At counter 0: a write goes to IDLE and sets Done next cycle; a read goes to CAPTURE.
  - CAPTURE: MemWrite=0. At the end of the cycle, load MemRData into InstrReg (IouD=0) or MDR (IouD=1). Go to IDLE and set Done.
- Done is registered and is high in the first IDLE cycle after completion. ReqReady is also high in that cycle, so back-to-back requests are legal.
- A store never modifies InstrReg or MDR. A fetch never modifies MDR. A load never modifies InstrReg.
- ReqValid in non-IDLE states is ignored. The controller keeps it asserted until ReqReady.
- The counter is $clog2(max(READ_LATENCY, WRITE_LATENCY)+1) bits wide.

## Timing
- Accept edge at end of cycle T. MemAddr and MemWrite are valid from T+1.
- Read: ACCESS in T+1..T+READ_LATENCY, CAPTURE in T+READ_LATENCY+1, Done and new InstrReg/MDR in T+READ_LATENCY+2. Default: Done at T+4.
- Write: MemWrite high in T+1..T+WRITE_LATENCY, Done in T+WRITE_LATENCY+1. Default: Done at T+2.
- Reset (Reset=0 at an edge), including mid-access, produces after that edge:
  - state IDLE; MemWrite=0; Done=0; AlignErr=0; ReqReady=1;
  - MemAddr=0, MemWData=0, InstrReg=0, MDR=0, counter=0.
- A request present during reset is not accepted.

## Configuration
- Macro MEM_ACCESS_ALIGN_CHECK_EN.
- Defined:
  - A request whose selected address has addr[1:0]≠0 is accepted but performs no memory access. MemWrite stays 0 and InstrReg/MDR are unchanged.
  - AlignErr and Done both pulse in cycle T+1; the state stays IDLE.
  - Aligned requests behave as described under Operation.
- Undefined: no check is made, address bits pass through unchanged, and AlignErr is tied 0. The port list is identical in both builds.

## Structure
- Shared package mem_seq_pkg:
  - state enum {IDLE, ACCESS, CAPTURE};
  - OPCODE_MSB/LSB and FUNCT_MSB/LSB field constants;
  - WORD_W = 32.
- Sub-module mem_lat_counter: loadable down-counter with a zero flag, parameterised by width. Everything else lives in mem_access_seq.

## Test plan
- Reset low for 2 cycles mid-read -> all outputs at reset values, ReqReady=1, InstrReg=0.
- Fetch with PCAddr=0x0000_0010 and MemRData=0x8C43_0004 (valid in T+3) -> MemAddr=0x10 from T+1, InstrReg=0x8C43_0004, OpCode=6'b100011, InstrArit=6'b000100, Done at T+4.
- Load with IouD=1, ALUOutAddr=0x24, MemRData=0xDEAD_BEEF -> MDR=0xDEADBEEF, InstrReg unchanged, Done at T+4.
- Store with ALUOutAddr=0x28, StoreData=0x1234_5678 -> MemWrite=1 only in T+1 with MemWData=0x12345678, Done at T+2, MDR/InstrReg unchanged.
- Back-to-back fetch then load with ReqValid held high -> second accept in the Done cycle, no lost or duplicated Done.
- MEM_ACCESS_ALIGN_CHECK_EN defined, load at ALUOutAddr=0x26 -> AlignErr=Done=1 at T+1, MemWrite=0, MDR unchanged. Same stimulus with the macro undefined -> normal access, AlignErr=0.
